// File: rtl/diag_scan_if.sv
// diag_scan_if: bundles the search request, row-RAM read bus and result signals of one
// diag_scan channel.
//   start/row_no          search request from the controller
//   ram_req/ram_addr      row-RAM read request, address {row, line}
//   ram_ack/ram_data      row-RAM read completion and 256-bit line
//   row_line/x_index      captured line and {line, k} of the result entry
//   found/flag/diag_done  status code, one-cycle result strobe, result-held level
//   busy                  search in progress
// modport master: the scan engine. modport slave: controller plus RAM side.
interface diag_scan_if #(
    parameter int unsigned LINE_BITS = 3
);
    logic                     start;
    logic [10:0]              row_no;
    logic                     ram_req;
    logic [11+LINE_BITS-1:0]  ram_addr;
    logic                     ram_ack;
    logic [255:0]             ram_data;
    logic [255:0]             row_line;
    logic [15:0]              x_index;
    logic [1:0]               found;
    logic                     flag;
    logic                     diag_done;
    logic                     busy;

    modport master (
        input  start, row_no, ram_ack, ram_data,
        output ram_req, ram_addr, row_line, x_index, found, flag, diag_done, busy
    );

    modport slave (
        output start, row_no, ram_ack, ram_data,
        input  ram_req, ram_addr, row_line, x_index, found, flag, diag_done, busy
    );
endinterface

// File: rtl/diag_scan.sv
// diag_scan: row fetch-and-scan engine for one search channel. Reads the packed entry lines
// of a row from row RAM one at a time and finds the diagonal entry (column == row).
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset
//   bus     diag_scan_if.master: start/row_no in, RAM read handshake, and the results
//           row_line, x_index, found, flag, diag_done, busy out.
// Entry k of a line sits at bits [255-16k -: 16]; bit 15 = valid, bits 10:0 = column.
module diag_scan #(
    parameter int unsigned MAX_LINES = 8,
    parameter int unsigned LINE_BITS = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    diag_scan_if.master  bus
);

    localparam int unsigned IdxPad = 16 - LINE_BITS - 4;

    typedef enum logic [1:0] {StIdle, StReq, StScan, StPost} state_e;

    state_e                 state_q, state_d;
    logic [10:0]            row_q, row_d;
    logic [LINE_BITS-1:0]   line_q, line_d;
    logic [255:0]           row_line_q, row_line_d;
    logic [15:0]            x_index_q, x_index_d;
    logic [1:0]             found_q, found_d;
    logic                   diag_done_q, diag_done_d;

    // Priority search: the first entry that is either invalid or matching decides.
    logic       hit_match;
    logic       hit_invalid;
    logic [3:0] hit_k;

    always_comb begin
        hit_match   = 1'b0;
        hit_invalid = 1'b0;
        hit_k       = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (!hit_match && !hit_invalid) begin
                if (!row_line_q[255-16*k]) begin
                    hit_invalid = 1'b1;
                    hit_k       = 4'(k);
                end else if (row_line_q[250-16*k -: 11] == row_q) begin
                    hit_match = 1'b1;
                    hit_k     = 4'(k);
                end
            end
        end
    end

    logic last_line;
    assign last_line = (line_q == LINE_BITS'(MAX_LINES - 1));

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        line_d      = line_q;
        row_line_d  = row_line_q;
        x_index_d   = x_index_q;
        found_d     = found_q;
        diag_done_d = diag_done_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    row_d       = bus.row_no;
                    line_d      = '0;
                    found_d     = 2'b00;
                    diag_done_d = 1'b0;
                    state_d     = StReq;
                end
            end
            StReq: begin
                if (bus.ram_ack) begin
                    row_line_d = bus.ram_data;
                    state_d    = StScan;
                end
            end
            StScan: begin
                if (hit_match) begin
                    found_d   = 2'b01;
                    x_index_d = {{IdxPad{1'b0}}, line_q, hit_k};
                    state_d   = StPost;
                end else if (hit_invalid) begin
                    found_d   = 2'b10;
                    x_index_d = {{IdxPad{1'b0}}, line_q, hit_k};
                    state_d   = StPost;
                end else if (last_line) begin
                    found_d   = 2'b11;
                    x_index_d = {{IdxPad{1'b0}}, line_q, 4'hF};
                    state_d   = StPost;
                end else begin
                    line_d  = line_q + 1'b1;
                    state_d = StReq;
                end
            end
            StPost: begin
                diag_done_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            row_q       <= '0;
            line_q      <= '0;
            row_line_q  <= '0;
            x_index_q   <= '0;
            found_q     <= 2'b00;
            diag_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            line_q      <= line_d;
            row_line_q  <= row_line_d;
            x_index_q   <= x_index_d;
            found_q     <= found_d;
            diag_done_q <= diag_done_d;
        end
    end

    assign bus.ram_req   = (state_q == StReq);
    assign bus.ram_addr  = {row_q, line_q};
    assign bus.row_line  = row_line_q;
    assign bus.x_index   = x_index_q;
    assign bus.found     = found_q;
    assign bus.flag      = (state_q == StPost);
    assign bus.diag_done = diag_done_q;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_diag_scan.sv
// tb_diag_scan: self-checking bench for diag_scan. A RAM model answers reads with a
// programmable wait and checks each read address against an expected-address queue;
// expected results are queued when a search is started and popped at the flag cycle.
module tb_diag_scan;
    localparam int unsigned MAX_LINES = 8;
    localparam int unsigned LINE_BITS = 3;

    typedef struct packed {
        logic [1:0]   found;
        logic [15:0]  idx;
        logic [255:0] line;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    diag_scan_if #(.LINE_BITS(LINE_BITS)) bus ();

    diag_scan #(
        .MAX_LINES (MAX_LINES),
        .LINE_BITS (LINE_BITS)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    res_t         exp_q[$];
    logic [13:0]  addr_q[$];
    logic [255:0] mem [0:127];
    int           errors = 0;
    int           checks = 0;
    int           ram_wait = 0;
    bit           ram_en = 1'b1;
    bit           force_ack = 1'b0;
    int           wait_cnt = 0;
    logic         flag_prev = 1'b0;

    // RAM model: answers ram_req after ram_wait idle cycles; checks each read address.
    initial begin
        logic [13:0] exp_a;
        bus.ram_ack  = 1'b0;
        bus.ram_data = '0;
        forever begin
            @(negedge clk);
            if (!ram_en) begin
                bus.ram_ack  = force_ack;
                bus.ram_data = {256{1'b1}};
                wait_cnt     = 0;
            end else if (bus.ram_req === 1'b1) begin
                if (wait_cnt >= ram_wait) begin
                    bus.ram_ack  = 1'b1;
                    bus.ram_data = mem[bus.ram_addr[6:0]];
                    wait_cnt     = 0;
                    checks++;
                    if (addr_q.size() == 0) begin
                        errors++;
                        $display("FAIL ram_read: unexpected read at addr %h", bus.ram_addr);
                    end else begin
                        exp_a = addr_q.pop_front();
                        if (bus.ram_addr !== exp_a) begin
                            errors++;
                            $display("FAIL ram_addr: got %h expected %h", bus.ram_addr, exp_a);
                        end
                    end
                end else begin
                    bus.ram_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.ram_ack = 1'b0;
                wait_cnt    = 0;
            end
        end
    end

    // flag must be a single-cycle pulse and never coincide with diag_done.
    always @(negedge clk) begin
        if (bus.flag === 1'b1) begin
            checks++;
            if (flag_prev || bus.diag_done !== 1'b0) begin
                errors++;
                $display("FAIL flag_pulse: flag_prev=%b diag_done=%b expected 0/0",
                         flag_prev, bus.diag_done);
            end
        end
        flag_prev = (bus.flag === 1'b1);
    end

    function automatic logic [255:0] filler_line();
        logic [255:0] l;
        for (int k = 0; k < 16; k++) l[255-16*k -: 16] = 16'h8000 | 16'(100 + k);
        return l;
    endfunction

    task automatic set_entry(input int a, input int k, input logic [15:0] v);
        mem[a][255-16*k -: 16] = v;
    endtask

    task automatic push_exp(input logic [1:0] f, input logic [15:0] idx, input int a);
        res_t r;
        r.found = f;
        r.idx   = idx;
        r.line  = mem[a];
        exp_q.push_back(r);
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 (start sampled at edge 0).
    task automatic pulse_start(input logic [10:0] row);
        bus.start  = 1'b1;
        bus.row_no = row;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    // Advances negedge by negedge until flag is seen or the budget runs out.
    task automatic wait_flag(input int first, output int cyc);
        cyc = first;
        while (bus.flag !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.ram_req !== 1'b0) begin errors++; $display("FAIL rst_ram_req: got %b expected 0", bus.ram_req); end
        checks++; if (bus.ram_addr !== '0) begin errors++; $display("FAIL rst_ram_addr: got %h expected 0", bus.ram_addr); end
        checks++; if (bus.row_line !== '0) begin errors++; $display("FAIL rst_row_line: got %h expected 0", bus.row_line); end
        checks++; if (bus.x_index !== '0) begin errors++; $display("FAIL rst_x_index: got %h expected 0", bus.x_index); end
        checks++; if (bus.found !== 2'b00) begin errors++; $display("FAIL rst_found: got %b expected 00", bus.found); end
        checks++; if (bus.flag !== 1'b0 || bus.diag_done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rst_status: flag/done/busy got %b%b%b expected 000",
                               bus.flag, bus.diag_done, bus.busy);
        end
    endtask

    task automatic test_match_zero_wait();
        res_t r;
        int   cyc;
        mem[8'h28] = filler_line();
        set_entry(8'h28, 3, 16'h8005);
        ram_wait = 0;
        addr_q.push_back(14'h028);
        push_exp(2'b01, 16'd3, 8'h28);
        pulse_start(11'd5);
        checks++; if (bus.ram_req !== 1'b1 || bus.ram_addr !== 14'h028) begin
            errors++; $display("FAIL zw_req_c1: req=%b addr=%h expected 1/028", bus.ram_req, bus.ram_addr);
        end
        checks++; if (bus.busy !== 1'b1 || bus.found !== 2'b00) begin
            errors++; $display("FAIL zw_busy_c1: busy=%b found=%b expected 1/00", bus.busy, bus.found);
        end
        wait_flag(1, cyc);
        checks++; if (cyc != 3) begin errors++; $display("FAIL zw_flag_cycle: got %0d expected 3", cyc); end
        r = exp_q.pop_front();
        checks++; if (bus.found !== r.found || bus.x_index !== r.idx) begin
            errors++; $display("FAIL zw_result: found=%b idx=%h expected %b/%h", bus.found, bus.x_index, r.found, r.idx);
        end
        checks++; if (bus.row_line !== r.line) begin errors++; $display("FAIL zw_row_line: got %h expected %h", bus.row_line, r.line); end
        @(negedge clk);
        checks++; if (bus.diag_done !== 1'b1 || bus.flag !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL zw_done_c4: done/flag/busy got %b%b%b expected 100", bus.diag_done, bus.flag, bus.busy);
        end
        checks++; if (bus.found !== 2'b01 || bus.x_index !== 16'd3) begin
            errors++; $display("FAIL zw_hold: found=%b idx=%h expected 01/0003", bus.found, bus.x_index);
        end
    endtask

    task automatic test_next_line();
        res_t r;
        int   cyc;
        mem[8'h10] = filler_line();
        mem[8'h11] = filler_line();
        set_entry(8'h11, 0, 16'h8002);
        ram_wait = 2;
        addr_q.push_back(14'h010);
        addr_q.push_back(14'h011);
        push_exp(2'b01, 16'h0010, 8'h11);
        pulse_start(11'd2);
        wait_flag(1, cyc);
        checks++; if (cyc != 9) begin errors++; $display("FAIL nl_flag_cycle: got %0d expected 9", cyc); end
        r = exp_q.pop_front();
        checks++; if (bus.found !== r.found || bus.x_index !== r.idx) begin
            errors++; $display("FAIL nl_result: found=%b idx=%h expected %b/%h", bus.found, bus.x_index, r.found, r.idx);
        end
        checks++; if (bus.row_line !== r.line) begin errors++; $display("FAIL nl_row_line: got %h expected %h", bus.row_line, r.line); end
        checks++; if (addr_q.size() != 0) begin errors++; $display("FAIL nl_reads: %0d reads missing expected 0", addr_q.size()); end
        @(negedge clk);
    endtask

    task automatic test_invalid_entry();
        res_t r;
        int   cyc;
        mem[8'h38] = filler_line();
        set_entry(8'h38, 4, 16'h0000);
        set_entry(8'h38, 5, 16'h8007);
        ram_wait = 0;
        addr_q.push_back(14'h038);
        push_exp(2'b10, 16'd4, 8'h38);
        pulse_start(11'd7);
        wait_flag(1, cyc);
        r = exp_q.pop_front();
        checks++; if (bus.flag !== 1'b1 || bus.found !== r.found || bus.x_index !== r.idx) begin
            errors++; $display("FAIL inv_result: flag=%b found=%b idx=%h expected 1/%b/%h",
                               bus.flag, bus.found, bus.x_index, r.found, r.idx);
        end
        checks++; if (addr_q.size() != 0) begin errors++; $display("FAIL inv_reads: %0d reads missing expected 0", addr_q.size()); end
        @(negedge clk);
    endtask

    task automatic test_line_limit();
        res_t r;
        int   cyc;
        for (int a = 8'h38; a <= 8'h3F; a++) begin
            mem[a] = filler_line();
            addr_q.push_back(14'(a));
        end
        ram_wait = 1;
        push_exp(2'b11, 16'h007F, 8'h3F);
        pulse_start(11'd7);
        wait_flag(1, cyc);
        checks++; if (cyc != 25) begin errors++; $display("FAIL ll_flag_cycle: got %0d expected 25", cyc); end
        r = exp_q.pop_front();
        checks++; if (bus.found !== r.found || bus.x_index !== r.idx) begin
            errors++; $display("FAIL ll_result: found=%b idx=%h expected %b/%h", bus.found, bus.x_index, r.found, r.idx);
        end
        checks++; if (bus.row_line !== r.line) begin errors++; $display("FAIL ll_row_line: got %h expected %h", bus.row_line, r.line); end
        checks++; if (addr_q.size() != 0) begin errors++; $display("FAIL ll_reads: %0d reads missing expected 0", addr_q.size()); end
        @(negedge clk);
    endtask

    task automatic test_priority();
        res_t r;
        int   cyc;
        mem[8'h18] = filler_line();
        set_entry(8'h18, 1, 16'hF903);  // column 0x103: differs from row only above bit 7
        set_entry(8'h18, 2, 16'hC003);  // column 3 with bit 14 set: still a match
        set_entry(8'h18, 9, 16'h8003);
        ram_wait = 0;
        addr_q.push_back(14'h018);
        push_exp(2'b01, 16'd2, 8'h18);
        pulse_start(11'd3);
        wait_flag(1, cyc);
        r = exp_q.pop_front();
        checks++; if (bus.flag !== 1'b1 || bus.found !== r.found || bus.x_index !== r.idx) begin
            errors++; $display("FAIL prio_result: flag=%b found=%b idx=%h expected 1/%b/%h",
                               bus.flag, bus.found, bus.x_index, r.found, r.idx);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midread();
        ram_en = 1'b0;
        pulse_start(11'd1);
        @(negedge clk);
        checks++; if (bus.ram_req !== 1'b1) begin errors++; $display("FAIL mr_pending: ram_req=%b expected 1", bus.ram_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.ram_req !== 1'b0 || bus.busy !== 1'b0 || bus.ram_addr !== '0) begin
            errors++; $display("FAIL mr_async: req=%b busy=%b addr=%h expected 0/0/0", bus.ram_req, bus.busy, bus.ram_addr);
        end
        checks++; if (bus.row_line !== '0 || bus.x_index !== '0 || bus.found !== 2'b00 || bus.diag_done !== 1'b0) begin
            errors++; $display("FAIL mr_async_res: line=%h idx=%h found=%b done=%b expected all 0",
                               bus.row_line, bus.x_index, bus.found, bus.diag_done);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        force_ack = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.ram_req !== 1'b0 || bus.row_line !== '0) begin
            errors++; $display("FAIL mr_late_ack: busy=%b req=%b line=%h expected 0/0/0", bus.busy, bus.ram_req, bus.row_line);
        end
        force_ack = 1'b0;
        ram_en    = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        res_t r;
        int   cyc;
        ram_wait = 3;
        addr_q.push_back(14'h028);
        push_exp(2'b01, 16'd3, 8'h28);
        pulse_start(11'd5);
        bus.start  = 1'b1;
        bus.row_no = 11'd9;
        repeat (2) @(negedge clk);
        bus.start  = 1'b0;
        wait_flag(3, cyc);
        checks++; if (cyc != 6) begin errors++; $display("FAIL si_flag_cycle: got %0d expected 6", cyc); end
        r = exp_q.pop_front();
        checks++; if (bus.found !== r.found || bus.x_index !== r.idx) begin
            errors++; $display("FAIL si_result: found=%b idx=%h expected %b/%h", bus.found, bus.x_index, r.found, r.idx);
        end
        bus.start = 1'b1;  // start during POST
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.ram_req !== 1'b0 || bus.diag_done !== 1'b1) begin
            errors++; $display("FAIL si_post_start: busy=%b req=%b done=%b expected 0/0/1", bus.busy, bus.ram_req, bus.diag_done);
        end
        checks++; if (addr_q.size() != 0) begin errors++; $display("FAIL si_reads: %0d reads missing expected 0", addr_q.size()); end
    endtask

    task automatic test_back_to_back();
        res_t r;
        int   cyc;
        ram_wait = 0;
        addr_q.push_back(14'h028);
        push_exp(2'b01, 16'd3, 8'h28);
        pulse_start(11'd5);
        wait_flag(1, cyc);
        r = exp_q.pop_front();
        checks++; if (bus.flag !== 1'b1 || bus.found !== r.found || bus.x_index !== r.idx) begin
            errors++; $display("FAIL b2b_first: flag=%b found=%b idx=%h expected 1/%b/%h",
                               bus.flag, bus.found, bus.x_index, r.found, r.idx);
        end
        @(negedge clk);  // first IDLE cycle after POST
        addr_q.push_back(14'h010);
        addr_q.push_back(14'h011);
        push_exp(2'b01, 16'h0010, 8'h11);
        pulse_start(11'd2);
        checks++; if (bus.diag_done !== 1'b0 || bus.found !== 2'b00 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: done=%b found=%b busy=%b expected 0/00/1", bus.diag_done, bus.found, bus.busy);
        end
        checks++; if (bus.x_index !== 16'd3) begin errors++; $display("FAIL b2b_idx_hold: got %h expected 0003", bus.x_index); end
        wait_flag(1, cyc);
        checks++; if (cyc != 5) begin errors++; $display("FAIL b2b_flag_cycle: got %0d expected 5", cyc); end
        r = exp_q.pop_front();
        checks++; if (bus.found !== r.found || bus.x_index !== r.idx || bus.row_line !== r.line) begin
            errors++; $display("FAIL b2b_second: found=%b idx=%h expected %b/%h", bus.found, bus.x_index, r.found, r.idx);
        end
        @(negedge clk);
        checks++; if (bus.flag !== 1'b0 || bus.diag_done !== 1'b1) begin
            errors++; $display("FAIL b2b_end: flag=%b done=%b expected 0/1", bus.flag, bus.diag_done);
        end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.row_no = '0;
        for (int a = 0; a < 128; a++) mem[a] = filler_line();
        test_reset();
        test_match_zero_wait();
        test_next_line();
        test_invalid_entry();
        test_line_limit();
        test_priority();
        test_reset_midread();
        test_start_ignored();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
